// File: rtl/id_stage.sv
// Decode stage of the LA32R 5-stage pipeline: holds one instruction, reads operands,
// resolves branches/jumps in ID and hands {pc, inst, operands, link, dest} to EX.
module id_stage (
   input  logic                clk,
   input  logic                resetn,
   input  logic                fs_to_ds_valid,
   input  logic [63:0]         fs_to_ds_bus,
   output logic                ds_allowin,
   output logic [33:0]         br_bus,
   input  logic                hazard_stall,
   output logic [4:0]          rf_raddr1,
   output logic [4:0]          rf_raddr2,
   input  logic [31:0]         rf_rdata1,
   input  logic [31:0]         rf_rdata2,
   input  logic                es_allowin,
   output logic                ds_to_es_valid,
   output logic [133:0]        ds_to_es_bus
);

   localparam int unsigned FS_BUS_W = 64;
   localparam int unsigned ES_BUS_W = 134;
   localparam int unsigned BR_BUS_W = 34;

   localparam logic [5:0] OP_JIRL = 6'h13;
   localparam logic [5:0] OP_B    = 6'h14;
   localparam logic [5:0] OP_BL   = 6'h15;
   localparam logic [5:0] OP_BEQ  = 6'h16;
   localparam logic [5:0] OP_BNE  = 6'h17;
   localparam logic [5:0] OP_BLT  = 6'h18;
   localparam logic [5:0] OP_BGE  = 6'h19;
   localparam logic [5:0] OP_BLTU = 6'h1a;
   localparam logic [5:0] OP_BGEU = 6'h1b;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic [31:0] rj_value;
      logic [31:0] rkd_value;
      logic        link;
      logic [4:0]  dest;
   } es_bus_t;

   typedef struct packed {
      logic        stall;
      logic        taken;
      logic [31:0] target;
   } br_bus_t;

   logic        r_ds_valid;
   logic [31:0] r_ds_pc;
   logic [31:0] r_ds_inst;

   logic [5:0]  w_op;
   logic [31:0] w_offs16;
   logic [31:0] w_offs26;
   logic        w_is_branch;
   logic        w_is_cmp;
   logic        w_cond;
   logic [31:0] w_target;
   logic        w_link;
   logic [4:0]  w_dest;
   logic        w_ready_go;
   logic        w_br_taken;
   es_bus_t     w_es_bus;
   br_bus_t     w_br_bus;

   // Pipeline register: a taken branch squashes whatever IF presents in the same cycle.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_ds_valid <= 1'b0;
         r_ds_pc    <= '0;
         r_ds_inst  <= '0;
      end else begin
         if (ds_allowin) begin
            r_ds_valid <= fs_to_ds_valid & ~w_br_taken;
         end
         if (fs_to_ds_valid && ds_allowin) begin
            r_ds_pc   <= fs_to_ds_bus[FS_BUS_W-1:32];
            r_ds_inst <= fs_to_ds_bus[31:0];
         end
      end
   end

   assign w_op     = r_ds_inst[31:26];
   assign w_offs16 = {{14{r_ds_inst[25]}}, r_ds_inst[25:10], 2'b00};
   assign w_offs26 = {{4{r_ds_inst[9]}}, r_ds_inst[9:0], r_ds_inst[25:10], 2'b00};

   // Branch decode, condition and target selection.
   always_comb begin
      w_is_branch = 1'b0;
      w_is_cmp    = 1'b0;
      w_cond      = 1'b0;
      w_target    = '0;
      w_link      = 1'b0;
      w_dest      = r_ds_inst[4:0];
      unique case (w_op)
         OP_JIRL: begin
            w_is_branch = 1'b1;
            w_cond      = 1'b1;
            w_target    = rf_rdata1 + w_offs16;
            w_link      = 1'b1;
         end
         OP_B: begin
            w_is_branch = 1'b1;
            w_cond      = 1'b1;
            w_target    = r_ds_pc + w_offs26;
            w_dest      = 5'd0;
         end
         OP_BL: begin
            w_is_branch = 1'b1;
            w_cond      = 1'b1;
            w_target    = r_ds_pc + w_offs26;
            w_link      = 1'b1;
            w_dest      = 5'd1;
         end
         OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
            w_is_branch = 1'b1;
            w_is_cmp    = 1'b1;
            w_target    = r_ds_pc + w_offs16;
            w_dest      = 5'd0;
            unique case (w_op)
               OP_BEQ:  w_cond = (rf_rdata1 == rf_rdata2);
               OP_BNE:  w_cond = (rf_rdata1 != rf_rdata2);
               OP_BLT:  w_cond = ($signed(rf_rdata1) <  $signed(rf_rdata2));
               OP_BGE:  w_cond = ($signed(rf_rdata1) >= $signed(rf_rdata2));
               OP_BLTU: w_cond = (rf_rdata1 <  rf_rdata2);
               default: w_cond = (rf_rdata1 >= rf_rdata2);
            endcase
         end
         default: begin
         end
      endcase
   end

   assign w_ready_go     = ~hazard_stall;
   assign ds_allowin     = ~r_ds_valid | (w_ready_go & es_allowin);
   assign ds_to_es_valid = r_ds_valid & w_ready_go;
   assign w_br_taken     = r_ds_valid & w_ready_go & es_allowin & w_is_branch & w_cond;

   assign w_br_bus.stall  = r_ds_valid & w_is_branch & hazard_stall;
   assign w_br_bus.taken  = w_br_taken;
   assign w_br_bus.target = w_br_taken ? w_target : 32'd0;
   assign br_bus          = BR_BUS_W'(w_br_bus);

   // Everything toward EX and the register file reads as zero while ID is empty.
   assign w_es_bus.pc        = r_ds_pc;
   assign w_es_bus.inst      = r_ds_inst;
   assign w_es_bus.rj_value  = rf_rdata1;
   assign w_es_bus.rkd_value = rf_rdata2;
   assign w_es_bus.link      = w_link;
   assign w_es_bus.dest      = w_dest;
   assign ds_to_es_bus       = r_ds_valid ? ES_BUS_W'(w_es_bus) : '0;

   assign rf_raddr1 = r_ds_valid ? r_ds_inst[9:5] : 5'd0;
   assign rf_raddr2 = !r_ds_valid ? 5'd0 : (w_is_cmp ? r_ds_inst[4:0] : r_ds_inst[14:10]);

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: table of single-instruction vectors plus hand-written
// squash, hazard, EX-backpressure and reset sequences; EX handoffs go through a scoreboard.
module tb_id_stage;

   logic         clk;
   logic         resetn;
   logic         fs_to_ds_valid;
   logic [63:0]  fs_to_ds_bus;
   logic         ds_allowin;
   logic [33:0]  br_bus;
   logic         hazard_stall;
   logic [4:0]   rf_raddr1;
   logic [4:0]   rf_raddr2;
   logic [31:0]  rf_rdata1;
   logic [31:0]  rf_rdata2;
   logic         es_allowin;
   logic         ds_to_es_valid;
   logic [133:0] ds_to_es_bus;

   int n_checks = 0;
   int n_fail   = 0;
   logic [133:0] sb[$];

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic [31:0] rj;
      logic [31:0] rkd;
      logic        taken;
      logic [31:0] target;
      logic        link;
      logic [4:0]  dest;
      logic [4:0]  raddr1;
      logic [4:0]  raddr2;
   } vec_t;

   vec_t vecs[11];

   id_stage dut (
      .clk            (clk),
      .resetn         (resetn),
      .fs_to_ds_valid (fs_to_ds_valid),
      .fs_to_ds_bus   (fs_to_ds_bus),
      .ds_allowin     (ds_allowin),
      .br_bus         (br_bus),
      .hazard_stall   (hazard_stall),
      .rf_raddr1      (rf_raddr1),
      .rf_raddr2      (rf_raddr2),
      .rf_rdata1      (rf_rdata1),
      .rf_rdata2      (rf_rdata2),
      .es_allowin     (es_allowin),
      .ds_to_es_valid (ds_to_es_valid),
      .ds_to_es_bus   (ds_to_es_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [133:0] act, input logic [133:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [133:0] es_exp(input logic [31:0] pc, input logic [31:0] inst,
                                           input logic [31:0] rj, input logic [31:0] rkd,
                                           input logic link, input logic [4:0] dest);
      return {pc, inst, rj, rkd, link, dest};
   endfunction

   // Scoreboard: every accepted EX handoff must match the oldest pushed expectation.
   always @(negedge clk) begin
      if (resetn && ds_to_es_valid && es_allowin) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_underflow: got unexpected bus %h expected none", ds_to_es_bus);
         end else begin
            check("es_bus", ds_to_es_bus, sb.pop_front());
         end
      end
   end

   task automatic drive_fs(input logic v, input logic [31:0] pc, input logic [31:0] inst);
      fs_to_ds_valid = v;
      fs_to_ds_bus   = {pc, inst};
   endtask

   task automatic next_drive();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vecs[0]  = '{32'h1c000010, 32'h58001085, 32'd7,        32'd7, 1'b1, 32'h1c000020, 1'b0, 5'd0, 5'd4,  5'd5};
      vecs[1]  = '{32'h1c000030, 32'h5c001085, 32'd7,        32'd7, 1'b0, 32'h0,        1'b0, 5'd0, 5'd4,  5'd5};
      vecs[2]  = '{32'h1c000040, 32'h57ffffff, 32'h0,        32'h0, 1'b1, 32'h1c00003c, 1'b1, 5'd1, 5'd31, 5'd31};
      vecs[3]  = '{32'h1c000080, 32'h4ffff823, 32'h1c000100, 32'h0, 1'b1, 32'h1c0000f8, 1'b1, 5'd3, 5'd1,  5'd30};
      vecs[4]  = '{32'h1c000100, 32'h60001085, 32'hffffffff, 32'd1, 1'b1, 32'h1c000110, 1'b0, 5'd0, 5'd4,  5'd5};
      vecs[5]  = '{32'h1c000140, 32'h68001085, 32'hffffffff, 32'd1, 1'b0, 32'h0,        1'b0, 5'd0, 5'd4,  5'd5};
      vecs[6]  = '{32'h1c000180, 32'h64001085, 32'hffffffff, 32'd1, 1'b0, 32'h0,        1'b0, 5'd0, 5'd4,  5'd5};
      vecs[7]  = '{32'h1c000200, 32'h6c001085, 32'hffffffff, 32'd1, 1'b1, 32'h1c000210, 1'b0, 5'd0, 5'd4,  5'd5};
      vecs[8]  = '{32'h1c000300, 32'h50040000, 32'h0,        32'h0, 1'b1, 32'h1c000700, 1'b0, 5'd0, 5'd0,  5'd0};
      vecs[9]  = '{32'h1c000400, 32'h00100c41, 32'h11,       32'h22, 1'b0, 32'h0,       1'b0, 5'd1, 5'd2,  5'd3};
      vecs[10] = '{32'h1c000500, 32'h5bfff085, 32'd3,        32'd3, 1'b1, 32'h1c0004f0, 1'b0, 5'd0, 5'd4,  5'd5};

      resetn       = 1'b0;
      hazard_stall = 1'b0;
      es_allowin   = 1'b1;
      rf_rdata1    = '0;
      rf_rdata2    = '0;
      drive_fs(1'b0, 32'h0, 32'h0);
      #12;
      check("rst_allowin", 134'(ds_allowin), 134'(1'b1));
      check("rst_br_bus", 134'(br_bus), 134'(0));
      check("rst_to_es", 134'({ds_to_es_valid, ds_to_es_bus}), 134'(0));
      @(negedge clk);
      resetn = 1'b1;

      // Table: each instruction spends one cycle in ID with EX ready.
      for (int i = 0; i < 11; i++) begin
         next_drive();
         drive_fs(1'b1, vecs[i].pc, vecs[i].inst);
         rf_rdata1 = '0;
         rf_rdata2 = '0;
         sb.push_back(es_exp(vecs[i].pc, vecs[i].inst, vecs[i].rj, vecs[i].rkd, vecs[i].link, vecs[i].dest));
         next_drive();
         drive_fs(1'b0, 32'h0, 32'h0);
         rf_rdata1 = vecs[i].rj;
         rf_rdata2 = vecs[i].rkd;
         @(negedge clk);
         check($sformatf("v%0d_br_bus", i), 134'(br_bus), 134'({1'b0, vecs[i].taken, vecs[i].target}));
         check($sformatf("v%0d_raddr1", i), 134'(rf_raddr1), 134'(vecs[i].raddr1));
         check($sformatf("v%0d_raddr2", i), 134'(rf_raddr2), 134'(vecs[i].raddr2));
         check($sformatf("v%0d_to_es_valid", i), 134'(ds_to_es_valid), 134'(1'b1));
      end

      // Taken beq squashes the instruction IF presents in the same cycle.
      next_drive();
      drive_fs(1'b1, 32'h1c000010, 32'h58001085);
      sb.push_back(es_exp(32'h1c000010, 32'h58001085, 32'd7, 32'd7, 1'b0, 5'd0));
      next_drive();
      drive_fs(1'b1, 32'h1c000014, 32'h00100c41);
      rf_rdata1 = 32'd7;
      rf_rdata2 = 32'd7;
      @(negedge clk);
      check("sq_br_bus", 134'(br_bus), 134'({2'b01, 32'h1c000020}));
      next_drive();
      drive_fs(1'b0, 32'h0, 32'h0);
      @(negedge clk);
      check("sq_to_es_valid", 134'(ds_to_es_valid), 134'(1'b0));
      check("sq_allowin", 134'(ds_allowin), 134'(1'b1));

      // Not-taken bne lets the following instruction through.
      next_drive();
      drive_fs(1'b1, 32'h1c000010, 32'h5c001085);
      sb.push_back(es_exp(32'h1c000010, 32'h5c001085, 32'd7, 32'd7, 1'b0, 5'd0));
      next_drive();
      drive_fs(1'b1, 32'h1c000014, 32'h00100c41);
      sb.push_back(es_exp(32'h1c000014, 32'h00100c41, 32'd1, 32'd2, 1'b0, 5'd1));
      @(negedge clk);
      check("bne_br_bus", 134'(br_bus), 134'(0));
      next_drive();
      drive_fs(1'b0, 32'h0, 32'h0);
      rf_rdata1 = 32'd1;
      rf_rdata2 = 32'd2;
      @(negedge clk);
      check("bne_next_valid", 134'(ds_to_es_valid), 134'(1'b1));
      check("bne_next_raddr2", 134'(rf_raddr2), 134'(5'd3));

      // Branch waiting on a hazard: stall reported, IF held, then a one-cycle taken pulse.
      next_drive();
      drive_fs(1'b1, 32'h1c000010, 32'h58001085);
      sb.push_back(es_exp(32'h1c000010, 32'h58001085, 32'd7, 32'd7, 1'b0, 5'd0));
      next_drive();
      drive_fs(1'b1, 32'h1c000014, 32'h00100c41);
      rf_rdata1    = 32'd7;
      rf_rdata2    = 32'd7;
      hazard_stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("hz%0d_br_bus", k), 134'(br_bus), 134'({2'b10, 32'h0}));
         check($sformatf("hz%0d_allowin", k), 134'(ds_allowin), 134'(1'b0));
         check($sformatf("hz%0d_to_es_valid", k), 134'(ds_to_es_valid), 134'(1'b0));
         next_drive();
      end
      hazard_stall = 1'b0;
      @(negedge clk);
      check("hz_rel_br_bus", 134'(br_bus), 134'({2'b01, 32'h1c000020}));
      next_drive();
      drive_fs(1'b0, 32'h0, 32'h0);
      @(negedge clk);
      check("hz_after_br_bus", 134'(br_bus), 134'(0));
      check("hz_after_valid", 134'(ds_to_es_valid), 134'(1'b0));

      // Same branch with EX not ready: taken held low until EX accepts.
      next_drive();
      drive_fs(1'b1, 32'h1c000010, 32'h58001085);
      sb.push_back(es_exp(32'h1c000010, 32'h58001085, 32'd7, 32'd7, 1'b0, 5'd0));
      next_drive();
      drive_fs(1'b1, 32'h1c000014, 32'h00100c41);
      es_allowin = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("ex%0d_br_bus", k), 134'(br_bus), 134'(0));
         check($sformatf("ex%0d_allowin", k), 134'(ds_allowin), 134'(1'b0));
         check($sformatf("ex%0d_to_es_valid", k), 134'(ds_to_es_valid), 134'(1'b1));
         next_drive();
      end
      es_allowin = 1'b1;
      @(negedge clk);
      check("ex_rel_br_bus", 134'(br_bus), 134'({2'b01, 32'h1c000020}));
      next_drive();
      drive_fs(1'b0, 32'h0, 32'h0);
      @(negedge clk);
      check("ex_after_br_bus", 134'(br_bus), 134'(0));

      // Asynchronous reset while a taken branch sits in ID.
      next_drive();
      drive_fs(1'b1, 32'h1c000010, 32'h58001085);
      next_drive();
      drive_fs(1'b0, 32'h0, 32'h0);
      #2;
      resetn = 1'b0;
      #1;
      check("arst_br_bus", 134'(br_bus), 134'(0));
      check("arst_to_es_valid", 134'(ds_to_es_valid), 134'(1'b0));
      check("arst_allowin", 134'(ds_allowin), 134'(1'b1));
      @(negedge clk);
      resetn = 1'b1;
      next_drive();
      @(negedge clk);
      check("post_rst_to_es", 134'(ds_to_es_valid), 134'(1'b0));

      repeat (2) @(posedge clk);
      check("sb_empty", 134'(sb.size()), 134'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
